midi_parser: RTL and testbench
==============================

Name: midi_parser

Overview:
- Parametrised successor to the single-channel MIDI receive FSM.
- Sits between the UART byte receiver (DATA/DV) and the voice/program logic.
- Decodes Note On/Off, Program Change, Control Change and Pitch Bend for any set of enabled channels, with running status, SysEx skipping and real-time byte transparency.
- Emits one fully assembled event per complete message.

Parameters:
- NUM_CH, 16, number of channel-enable bits (1..16); channels >= NUM_CH are always ignored.
- VEL0_IS_OFF, 1, when 1 a Note On with velocity 0 is reported as Note Off.
- EN_CC, 1, when 0 Control Change messages are skipped (data bytes consumed, no event).
- EN_BEND, 1, when 0 Pitch Bend messages are skipped.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- CE  in  1  clock enable; all state updates are qualified by CE.
- CH_EN  in  NUM_CH  per-channel enable mask; bit n accepts channel n.
- DATA  in  8  received MIDI byte.
- DV  in  1  DATA valid; one byte per CE-qualified cycle with DV=1.
- EV_VALID  out  1  one-cycle event strobe.
- EV_TYPE  out  3  event type: 0 none, 1 note off, 2 note on, 3 program, 4 CC, 5 bend.
- EV_CH  out  4  channel of the event.
- EV_D1  out  7  note, program, CC number, or bend LSB.
- EV_D2  out  7  velocity, CC value, or bend MSB; 0 for program events.
- STATUS  out  3  current FSM state, for debug and LEDs.

Behaviour:
- Clocking: one clock CLK. RST is synchronous and active-high, and it wins over CE and DV. Registers update only when CE=1, except EV_VALID, which clears every CLK edge.
- Reset values: state=IDLE, run_status=0 (invalid), all EV_* outputs=0, STATUS=0.
- States:
  - IDLE (0): no running status.
  - DATA1 (1): waiting for the first data byte.
  - DATA2 (2): waiting for the second data byte.
  - SKIP1 (3) and SKIP2 (4): consume data bytes of an ignored message.
  - SYSEX (5): discard bytes until a terminator.
- Real-time bytes (F8..FE) with DV: ignored entirely. State, running status and the partially assembled message are preserved.
- FF (system reset) with DV: state returns to IDLE and running status is cleared. Already emitted outputs are unchanged.
- Any other status byte (80..F7) in any state aborts the current message.
  - Channel voice byte (8x..Ex): latch it as run_status.
    - Accepted when the type is enabled, ch < NUM_CH and CH_EN[ch]=1. Go to DATA1.
    - Otherwise go to SKIP1 (types 8,9,A,B,E) or SKIP2 (types C,D); the running status is kept.
    - Types A (poly pressure) and D (channel pressure) are always skipped.
  - F0: go to SYSEX and clear running status.
  - F1..F7: clear running status and go to IDLE. F7 also terminates SYSEX.
- Data bytes (bit7=0):
  - IDLE: discard.
  - DATA1: latch d1. Single-byte types (C) emit immediately; two-byte types go to DATA2.
  - DATA2: latch d2 and emit.
  - SKIP1 goes to SKIP2; SKIP2 goes to SKIP1 if the skipped type is a 2-byte type, otherwise it stays in SKIP2 (running-status skip).
  - SYSEX: discard.
- Emit: on the CE-qualified edge that accepts the last data byte, register EV_TYPE/CH/D1/D2 and pulse EV_VALID for exactly 1 CLK cycle. EV_* fields hold until the next event.
  - Latency: 1 cycle from the last DV byte.
  - After an emit, state returns to DATA1 with run_status retained (running status).
- VEL0_IS_OFF=1 and 9x with d2=0: EV_TYPE=1 (note off).
- Mid-message CH_EN change: the mask is sampled only when the status byte arrives; messages already in progress complete as accepted or skipped.
- Unreachable state codes go to IDLE.

Decomposition:
- Package midi_pkg holds:
  - Status nibble constants: NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROGRAM=C, CH_AT=D, BEND=E.
  - System bytes: F0 SysEx, F7 EOX, FF reset.
  - EV_TYPE encodings.
  - FSM state encodings.
- Optional sub-module midi_status_decode (combinational): maps a status byte plus CH_EN plus parameters to accept/skip, data-byte count and event type. It is shared with a future MIDI-thru filter.

Test Plan:
- CH_EN=0x0001, bytes 90 3C 64 -> one EV_VALID one cycle after 64, with TYPE=2, CH=0, D1=0x3C, D2=0x64.
- Running status: 91 40 7F 40 00 with CH_EN bit1=1 and VEL0_IS_OFF=1 -> two events, (2,1,40,7F) then (1,1,40,00).
- Real-time interleave: 90 3C F8 64 FE -> one note-on event with D2=0x64; no extra event; state is DATA1 afterwards.
- Masked channel plus running status: CH_EN=0x0001, bytes 92 3C 64 3D 65 C0 05 -> only the event (3,0,05,00); STATUS passes through SKIP1/SKIP2.
- SysEx abort: F0 7E 01 F7 3C 64 -> no events; IDLE after F7; trailing data is discarded.
- Reset and FF: RST asserted in DATA2 mid-message -> IDLE and outputs 0 on the next edge. In a separate run, 90 3C FF 64 -> no event and state IDLE.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants, event/state encodings and message-length helper
// for the MIDI receive parser and future MIDI-thru filter.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROGRAM  = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    localparam logic [7:0] SYS_EX    = 8'hF0;
    localparam logic [7:0] SYS_EOX   = 8'hF7;
    localparam logic [7:0] SYS_RESET = 8'hFF;

    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_NOTE_OFF = 3'd1,
        EV_NOTE_ON  = 3'd2,
        EV_PROGRAM  = 3'd3,
        EV_CC       = 3'd4,
        EV_BEND     = 3'd5
    } ev_type_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA1 = 3'd1,
        ST_DATA2 = 3'd2,
        ST_SKIP1 = 3'd3,
        ST_SKIP2 = 3'd4,
        ST_SYSEX = 3'd5
    } state_t;

    // Program change and channel pressure carry one data byte, all others two.
    function automatic logic msg_two_byte(input logic [3:0] nib);
        return !(nib == PROGRAM || nib == CH_AT);
    endfunction

endpackage

// File: rtl/midi_status_decode.sv
// Combinational channel-voice status decoder: accept/skip decision,
// data-byte count and event type for one status byte.
module midi_status_decode
    import midi_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int EN_CC   = 1,
    parameter int EN_BEND = 1
) (
    input  logic [7:0]        stat,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              accept,
    output logic              two_byte,
    output ev_type_t          ev_type
);

    logic [15:0] en16;
    logic        type_en;

    // Zero-extension makes channels >= NUM_CH read as disabled.
    assign en16 = 16'(ch_en);

    always_comb begin
        type_en = 1'b0;
        ev_type = EV_NONE;
        case (stat[7:4])
            NOTE_OFF: begin type_en = 1'b1;          ev_type = EV_NOTE_OFF; end
            NOTE_ON:  begin type_en = 1'b1;          ev_type = EV_NOTE_ON;  end
            CC:       begin type_en = (EN_CC != 0);   ev_type = EV_CC;       end
            PROGRAM:  begin type_en = 1'b1;          ev_type = EV_PROGRAM;  end
            BEND:     begin type_en = (EN_BEND != 0); ev_type = EV_BEND;     end
            POLY_AT, CH_AT: type_en = 1'b0;
            default:  type_en = 1'b0;
        endcase
    end

    assign two_byte = msg_two_byte(stat[7:4]);
    assign accept   = type_en && en16[stat[3:0]];

endmodule

// File: rtl/midi_parser.sv
// MIDI receive parser: running status, SysEx skipping, real-time transparency,
// emits one assembled channel-voice event per complete message.
module midi_parser
    import midi_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int VEL0_IS_OFF = 1,
    parameter int EN_CC       = 1,
    parameter int EN_BEND     = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic [7:0]        DATA,
    input  logic              DV,
    output logic              EV_VALID,
    output logic [2:0]        EV_TYPE,
    output logic [3:0]        EV_CH,
    output logic [6:0]        EV_D1,
    output logic [6:0]        EV_D2,
    output logic [2:0]        STATUS
);

    state_t     state, next_state;
    logic [7:0] run_status;
    ev_type_t   run_type;
    logic [6:0] d1;

    logic       dec_accept, dec_two;
    ev_type_t   dec_type;
    logic       run_two;
    logic       set_run, clr_run, latch_d1, emit;
    ev_type_t   ev_type_nxt;
    logic [6:0] ev_d1_nxt, ev_d2_nxt;

    midi_status_decode #(
        .NUM_CH  (NUM_CH),
        .EN_CC   (EN_CC),
        .EN_BEND (EN_BEND)
    ) u_dec (
        .stat     (DATA),
        .ch_en    (CH_EN),
        .accept   (dec_accept),
        .two_byte (dec_two),
        .ev_type  (dec_type)
    );

    assign run_two = msg_two_byte(run_status[7:4]);

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else if (CE)
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        set_run    = 1'b0;
        clr_run    = 1'b0;
        latch_d1   = 1'b0;
        emit       = 1'b0;
        if (!(state inside {ST_IDLE, ST_DATA1, ST_DATA2, ST_SKIP1, ST_SKIP2, ST_SYSEX})) begin
            next_state = ST_IDLE;
        end else if (DV) begin
            if (DATA == SYS_RESET) begin
                next_state = ST_IDLE;
                clr_run    = 1'b1;
            end else if (DATA[7:3] == 5'b11111) begin
                // Real-time bytes pass through without disturbing the message.
            end else if (DATA[7] && DATA[7:4] != 4'hF) begin
                set_run    = 1'b1;
                next_state = dec_accept ? ST_DATA1 : (dec_two ? ST_SKIP1 : ST_SKIP2);
            end else if (DATA == SYS_EX) begin
                next_state = ST_SYSEX;
                clr_run    = 1'b1;
            end else if (DATA[7]) begin
                // F1..F7, including SYS_EOX which ends a SysEx dump.
                next_state = ST_IDLE;
                clr_run    = 1'b1;
            end else begin
                case (state)
                    ST_DATA1: begin
                        latch_d1 = 1'b1;
                        if (run_two) begin
                            next_state = ST_DATA2;
                        end else begin
                            emit       = 1'b1;
                            next_state = ST_DATA1;
                        end
                    end
                    ST_DATA2: begin
                        emit       = 1'b1;
                        next_state = ST_DATA1;
                    end
                    ST_SKIP1: next_state = ST_SKIP2;
                    ST_SKIP2: next_state = run_two ? ST_SKIP1 : ST_SKIP2;
                    default:  next_state = state;
                endcase
            end
        end
    end

    always_comb begin
        ev_type_nxt = run_type;
        ev_d1_nxt   = d1;
        ev_d2_nxt   = DATA[6:0];
        if (state == ST_DATA1) begin
            ev_d1_nxt = DATA[6:0];
            ev_d2_nxt = 7'd0;
        end else if (VEL0_IS_OFF != 0 && run_type == EV_NOTE_ON && DATA[6:0] == 7'd0) begin
            ev_type_nxt = EV_NOTE_OFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            run_status <= 8'd0;
            run_type   <= EV_NONE;
            d1         <= 7'd0;
            EV_VALID   <= 1'b0;
            EV_TYPE    <= 3'd0;
            EV_CH      <= 4'd0;
            EV_D1      <= 7'd0;
            EV_D2      <= 7'd0;
        end else begin
            EV_VALID <= 1'b0;
            if (CE) begin
                if (set_run) begin
                    run_status <= DATA;
                    run_type   <= dec_type;
                end else if (clr_run) begin
                    run_status <= 8'd0;
                    run_type   <= EV_NONE;
                end
                if (latch_d1)
                    d1 <= DATA[6:0];
                if (emit) begin
                    EV_VALID <= 1'b1;
                    EV_TYPE  <= ev_type_nxt;
                    EV_CH    <= run_status[3:0];
                    EV_D1    <= ev_d1_nxt;
                    EV_D2    <= ev_d2_nxt;
                end
            end
        end
    end

    assign STATUS = state;

endmodule

// File: tb/tb_midi_parser.sv
// Directed vector bench for midi_parser: table of per-cycle inputs with
// hand-computed outputs, plus hand-written clock-enable and pulse-width sequences.
module tb_midi_parser;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE  = 1'b1;
    logic [15:0] CH_EN = 16'h0001;
    logic [7:0]  DATA = 8'h00;
    logic        DV = 1'b0;
    logic        EV_VALID;
    logic [2:0]  EV_TYPE;
    logic [3:0]  EV_CH;
    logic [6:0]  EV_D1;
    logic [6:0]  EV_D2;
    logic [2:0]  STATUS;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        dv;
        logic [7:0]  data;
        logic [15:0] chen;
        logic        vld;
        logic [2:0]  typ;
        logic [3:0]  ch;
        logic [6:0]  d1;
        logic [6:0]  d2;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[$];

    midi_parser #(
        .NUM_CH      (16),
        .VEL0_IS_OFF (1),
        .EN_CC       (1),
        .EN_BEND     (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .CH_EN    (CH_EN),
        .DATA     (DATA),
        .DV       (DV),
        .EV_VALID (EV_VALID),
        .EV_TYPE  (EV_TYPE),
        .EV_CH    (EV_CH),
        .EV_D1    (EV_D1),
        .EV_D2    (EV_D2),
        .STATUS   (STATUS)
    );

    always #5 CLK = ~CLK;

    task automatic v(input logic rst, input logic ce, input logic dv, input logic [7:0] data,
                     input logic [15:0] chen, input logic vld, input logic [2:0] typ,
                     input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2,
                     input logic [2:0] st);
        vec_t r;
        r.rst = rst; r.ce = ce; r.dv = dv; r.data = data; r.chen = chen;
        r.vld = vld; r.typ = typ; r.ch = ch; r.d1 = d1; r.d2 = d2; r.st = st;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        DATA = b; DV = 1'b1; CE = 1'b1; RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic got;
        int   waited;

        // reset
        v(1,1,0,8'h00,16'h0001, 0,0,0,7'h00,7'h00,0);
        // basic note on, channel 0
        v(0,1,1,8'h90,16'h0001, 0,0,0,7'h00,7'h00,1);
        v(0,1,1,8'h3C,16'h0001, 0,0,0,7'h00,7'h00,2);
        v(0,1,1,8'h64,16'h0001, 1,2,0,7'h3C,7'h64,1);
        v(0,1,0,8'h00,16'h0001, 0,2,0,7'h3C,7'h64,1);
        // running status with velocity-0 note off
        v(0,1,1,8'h91,16'h0002, 0,2,0,7'h3C,7'h64,1);
        v(0,1,1,8'h40,16'h0002, 0,2,0,7'h3C,7'h64,2);
        v(0,1,1,8'h7F,16'h0002, 1,2,1,7'h40,7'h7F,1);
        v(0,1,1,8'h40,16'h0002, 0,2,1,7'h40,7'h7F,2);
        v(0,1,1,8'h00,16'h0002, 1,1,1,7'h40,7'h00,1);
        // real-time interleave
        v(0,1,1,8'h90,16'h0001, 0,1,1,7'h40,7'h00,1);
        v(0,1,1,8'h3C,16'h0001, 0,1,1,7'h40,7'h00,2);
        v(0,1,1,8'hF8,16'h0001, 0,1,1,7'h40,7'h00,2);
        v(0,1,1,8'h64,16'h0001, 1,2,0,7'h3C,7'h64,1);
        v(0,1,1,8'hFE,16'h0001, 0,2,0,7'h3C,7'h64,1);
        // masked channel with running status, then program change
        v(0,1,1,8'h92,16'h0001, 0,2,0,7'h3C,7'h64,3);
        v(0,1,1,8'h3C,16'h0001, 0,2,0,7'h3C,7'h64,4);
        v(0,1,1,8'h64,16'h0001, 0,2,0,7'h3C,7'h64,3);
        v(0,1,1,8'h3D,16'h0001, 0,2,0,7'h3C,7'h64,4);
        v(0,1,1,8'h65,16'h0001, 0,2,0,7'h3C,7'h64,3);
        v(0,1,1,8'hC0,16'h0001, 0,2,0,7'h3C,7'h64,1);
        v(0,1,1,8'h05,16'h0001, 1,3,0,7'h05,7'h00,1);
        // SysEx abort and trailing data
        v(0,1,1,8'hF0,16'h0001, 0,3,0,7'h05,7'h00,5);
        v(0,1,1,8'h7E,16'h0001, 0,3,0,7'h05,7'h00,5);
        v(0,1,1,8'h01,16'h0001, 0,3,0,7'h05,7'h00,5);
        v(0,1,1,8'hF7,16'h0001, 0,3,0,7'h05,7'h00,0);
        v(0,1,1,8'h3C,16'h0001, 0,3,0,7'h05,7'h00,0);
        v(0,1,1,8'h64,16'h0001, 0,3,0,7'h05,7'h00,0);
        // CC, bend, note off
        v(0,1,1,8'hB0,16'h0001, 0,3,0,7'h05,7'h00,1);
        v(0,1,1,8'h07,16'h0001, 0,3,0,7'h05,7'h00,2);
        v(0,1,1,8'h64,16'h0001, 1,4,0,7'h07,7'h64,1);
        v(0,1,1,8'hE0,16'h0001, 0,4,0,7'h07,7'h64,1);
        v(0,1,1,8'h00,16'h0001, 0,4,0,7'h07,7'h64,2);
        v(0,1,1,8'h40,16'h0001, 1,5,0,7'h00,7'h40,1);
        v(0,1,1,8'h80,16'h0001, 0,5,0,7'h00,7'h40,1);
        v(0,1,1,8'h3C,16'h0001, 0,5,0,7'h00,7'h40,2);
        v(0,1,1,8'h40,16'h0001, 1,1,0,7'h3C,7'h40,1);
        // single-byte running status on channel 3
        v(0,1,1,8'hC3,16'h0008, 0,1,0,7'h3C,7'h40,1);
        v(0,1,1,8'h11,16'h0008, 1,3,3,7'h11,7'h00,1);
        v(0,1,1,8'h22,16'h0008, 1,3,3,7'h22,7'h00,1);
        // poly and channel pressure always skipped; F1 clears running status
        v(0,1,1,8'hA0,16'h0001, 0,3,3,7'h22,7'h00,3);
        v(0,1,1,8'h3C,16'h0001, 0,3,3,7'h22,7'h00,4);
        v(0,1,1,8'h64,16'h0001, 0,3,3,7'h22,7'h00,3);
        v(0,1,1,8'hD0,16'h0001, 0,3,3,7'h22,7'h00,4);
        v(0,1,1,8'h05,16'h0001, 0,3,3,7'h22,7'h00,4);
        v(0,1,1,8'h06,16'h0001, 0,3,3,7'h22,7'h00,4);
        v(0,1,1,8'hF1,16'h0001, 0,3,3,7'h22,7'h00,0);
        v(0,1,1,8'h3C,16'h0001, 0,3,3,7'h22,7'h00,0);
        // clock enable gating
        v(0,0,1,8'h90,16'h0001, 0,3,3,7'h22,7'h00,0);
        v(0,1,1,8'h90,16'h0001, 0,3,3,7'h22,7'h00,1);
        v(0,1,1,8'h3C,16'h0001, 0,3,3,7'h22,7'h00,2);
        v(0,0,1,8'h64,16'h0001, 0,3,3,7'h22,7'h00,2);
        v(0,1,1,8'h64,16'h0001, 1,2,0,7'h3C,7'h64,1);
        v(0,0,0,8'h00,16'h0001, 0,2,0,7'h3C,7'h64,1);
        // mask sampled only at status byte
        v(0,1,1,8'h91,16'h0002, 0,2,0,7'h3C,7'h64,1);
        v(0,1,1,8'h3C,16'h0000, 0,2,0,7'h3C,7'h64,2);
        v(0,1,1,8'h64,16'h0000, 1,2,1,7'h3C,7'h64,1);
        v(0,1,1,8'h92,16'h0000, 0,2,1,7'h3C,7'h64,3);
        v(0,1,1,8'h3C,16'hFFFF, 0,2,1,7'h3C,7'h64,4);
        v(0,1,1,8'h64,16'hFFFF, 0,2,1,7'h3C,7'h64,3);
        // reset mid-message in DATA2
        v(0,1,1,8'h90,16'h0001, 0,2,1,7'h3C,7'h64,1);
        v(0,1,1,8'h3C,16'h0001, 0,2,1,7'h3C,7'h64,2);
        v(1,1,1,8'h64,16'h0001, 0,0,0,7'h00,7'h00,0);
        // FF system reset mid-message
        v(0,1,1,8'h90,16'h0001, 0,0,0,7'h00,7'h00,1);
        v(0,1,1,8'h3C,16'h0001, 0,0,0,7'h00,7'h00,2);
        v(0,1,1,8'hFF,16'h0001, 0,0,0,7'h00,7'h00,0);
        v(0,1,1,8'h64,16'h0001, 0,0,0,7'h00,7'h00,0);
        // RST wins over CE=0
        v(0,1,1,8'h90,16'h0001, 0,0,0,7'h00,7'h00,1);
        v(0,1,1,8'h3C,16'h0001, 0,0,0,7'h00,7'h00,2);
        v(0,1,1,8'h64,16'h0001, 1,2,0,7'h3C,7'h64,1);
        v(1,0,0,8'h00,16'h0001, 0,0,0,7'h00,7'h00,0);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; CE = vecs[i].ce; DV = vecs[i].dv;
            DATA = vecs[i].data; CH_EN = vecs[i].chen;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d", i),
                  {7'd0, EV_VALID, EV_TYPE, EV_CH, EV_D1, EV_D2, STATUS},
                  {7'd0, vecs[i].vld, vecs[i].typ, vecs[i].ch, vecs[i].d1, vecs[i].d2, vecs[i].st});
        end

        // Event strobe lasts exactly one cycle.
        CH_EN = 16'h0001;
        send(8'h90);
        send(8'h3C);
        send(8'h64);
        check("pulse_on", {31'd0, EV_VALID}, 32'd1);
        @(negedge CLK);
        DV = 1'b0;
        @(posedge CLK);
        #1;
        check("pulse_off", {31'd0, EV_VALID}, 32'd0);

        // Last CC byte held on DATA while CE toggles; accepted only on the CE cycle.
        send(8'hB0);
        send(8'h07);
        got = 1'b0;
        waited = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge CLK);
            DATA = 8'h7F; DV = 1'b1; CE = (k % 2 == 1);
            @(posedge CLK);
            #1;
            waited++;
            if (EV_VALID) got = 1'b1;
        end
        check("cc_ce_seen", {31'd0, got}, 32'd1);
        check("cc_ce_wait", waited, 32'd2);
        check("cc_ce_fields", {13'd0, EV_TYPE, EV_CH, EV_D1, EV_D2}, {13'd0, 3'd4, 4'd0, 7'h07, 7'h7F});
        @(negedge CLK);
        DV = 1'b0; CE = 1'b1;
        @(posedge CLK);
        #1;
        check("cc_after", {29'd0, STATUS}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
